pe_req_arbiter: RTL and testbench
=================================

// Module: pe_req_arbiter
// PURPOSE
//  Sequential arbiter that shares a single downstream resource among N requesters.
//  Priority-encoder selection is wrapped in a grant/hold/release state machine.
//  Sits between the requesting PE channels and the shared resource.
//  Drives a one-hot grant, an encoded grant index and a valid flag.
//  Bounds tenure with a hold timeout.
// PARAMETERS
//  N        3   number of requesters (2..8)
//  IDW      2   grant index width; IDW >= clog2(N)
//  MAX_HOLD 8   max cycles one grant may be held before forced release (1..255)
// PORTS
//  clk       in   1    rising-edge clock
//  rst_n     in   1    synchronous active-low reset
//  req       in   N    request vector; bit i held high while requester i wants/uses resource
//  gnt       out  N    one-hot grant, registered
//  gnt_id    out  IDW  encoded index of granted requester, registered
//  gnt_vld   out  1    high while gnt is non-zero
//  timeout   out  1    1-cycle pulse when a grant is revoked by MAX_HOLD expiry
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, gnt=0, gnt_id=0, gnt_vld=0, timeout=0,
//    hold_cnt=0, mask=0; ROUND_ROBIN_EN pointer=0. Reset mid-grant drops gnt the next edge.
//  - States: IDLE, GRANT, GAP.
//  - IDLE: eligible = req & ~mask. If eligible != 0, select a winner (see CONFIGURATION).
//    Next edge: gnt = one-hot of winner, gnt_id = index, gnt_vld = 1, hold_cnt = 1,
//    -> GRANT. Latency req->gnt = 1 cycle from IDLE.
//  - GRANT:
//    - If req[gnt_id] = 0: next edge gnt = 0 -> GAP.
//    - Else if hold_cnt = MAX_HOLD: next edge gnt = 0, timeout = 1 for one cycle,
//      mask[gnt_id] = 1 -> GAP.
//    - Else hold_cnt increments (saturating width clog2(MAX_HOLD+1)).
//    - Other requests arriving during GRANT are ignored, with no preemption.
//  - GAP: exactly one idle cycle, gnt = 0, then -> IDLE. Guarantees a dead cycle
//    between tenures. Minimum back-to-back spacing = 3 cycles per grant.
//  - Mask: mask[i] clears on any edge where req[i] = 0, so a timed-out requester
//    must deassert req for >= 1 cycle before re-arbitration.
//  - Simultaneous release and timeout (req drops on the cycle hold_cnt = MAX_HOLD):
//    release wins, timeout stays 0, no mask set.
//  - req bits >= N do not exist. gnt_id is zero-extended to IDW.
//  - All outputs are registered. No combinational path req->gnt.
// CONFIGURATION
//  ROUND_ROBIN_EN
//  - Undefined (default): fixed priority, highest index wins (req=3'b101 -> index 2).
//  - Defined: rotating priority with a pointer reg.
//    - Search starts at pointer and goes upward, wrapping N-1 -> 0.
//    - On every grant issue, pointer = (winner+1) mod N.
//    - Pointer is unaffected by timeout or GAP.
// TESTING
//  1. Reset with req=3'b111 held -> all outputs 0 while rst_n=0.
//     First grant 1 cycle after rst_n=1: gnt=3'b100, gnt_id=2.
//  2. req=3'b010 held 3 cycles then dropped -> gnt=3'b010 for 3 cycles,
//     1 GAP cycle, gnt_vld=0, timeout never asserts.
//  3. req=3'b001 held 20 cycles, MAX_HOLD=8 -> gnt high exactly 8 cycles, timeout pulse 1 cycle,
//     no regrant to 0 until req drops >= 1 cycle and reasserts.
//  4. Default build, req=3'b111 constant, each requester drops after 2 cycles of grant
//     then reasserts -> requester 2 starves 0 and 1 (grants always index 2).
//  5. ROUND_ROBIN_EN, same stimulus as 4 -> grant sequence 0,1,2,0,1,2 with 1 GAP cycle
//     between tenures.
//  6. Mid-GRANT (gnt_id=1) assert rst_n=0 for 1 cycle -> gnt=0 next edge, hold_cnt=0,
//     mask=0. After release: fresh arbitration from IDLE, pointer=0.

Source files
------------

// File: rtl/pe_req_arbiter.sv
// pe_req_arbiter: grant/hold/release arbiter sharing one resource among N requesters.
// Optional macro ROUND_ROBIN_EN: rotating priority (default is fixed, highest index wins).
module pe_req_arbiter #(
    parameter int N        = 3,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_vld,
    output logic           timeout
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   gnt_q;
    logic [N-1:0]   gnt_d;
    logic [IDW-1:0] gnt_id_q;
    logic [IDW-1:0] gnt_id_d;
    logic           gnt_vld_q;
    logic           gnt_vld_d;
    logic           timeout_q;
    logic           timeout_d;
    logic [CW-1:0]  hold_cnt_q;
    logic [CW-1:0]  hold_cnt_d;
    logic [N-1:0]   mask_q;
    logic [N-1:0]   mask_d;

    logic [N-1:0]   eligible;
    logic [N-1:0]   mask_set;
    logic [IDW-1:0] winner;
    logic [N-1:0]   winner_oh;
    logic           owner_req;

    assign eligible  = req & ~mask_q;
    assign winner_oh = N'(1) << winner;
    // gnt_q is one-hot, so this is req[gnt_id] without a variable index
    assign owner_req = |(req & gnt_q);

`ifdef ROUND_ROBIN_EN
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [2*N-1:0] rot_dbl;
    logic [N-1:0]   rot;
    logic [IDW:0]   cand;

    // rotate eligible so bit k corresponds to requester (ptr + k) mod N
    assign rot_dbl = {eligible, eligible} >> ptr_q;
    assign rot     = rot_dbl[N-1:0];

    // first eligible requester at or above the pointer, wrapping
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                cand = {1'b0, ptr_q} + (IDW+1)'(k);
                if (cand >= (IDW+1)'(N)) begin
                    cand = cand - (IDW+1)'(N);
                end
                winner = cand[IDW-1:0];
            end
        end
    end
`else
    // fixed priority: highest eligible index wins
    always_comb begin
        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i]) begin
                winner = IDW'(i);
            end
        end
    end
`endif

    // next-state and registered-output computation for the grant FSM
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        gnt_vld_d  = gnt_vld_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        mask_set   = '0;
`ifdef ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d    = GRANT;
                    gnt_d      = winner_oh;
                    gnt_id_d   = winner;
                    gnt_vld_d  = 1'b1;
                    hold_cnt_d = CW'(1);
`ifdef ROUND_ROBIN_EN
                    if (winner == IDW'(N - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = winner + 1'b1;
                    end
`endif
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    // voluntary release takes precedence over expiry
                    state_d    = GAP;
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == CW'(MAX_HOLD)) begin
                    state_d    = GAP;
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                    mask_set   = gnt_q;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_id_d  = '0;
                gnt_vld_d = 1'b0;
            end
        endcase
        // a masked requester is re-enabled once it drops its request
        mask_d = (mask_q & req) | mask_set;
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
        end
    end

`ifdef ROUND_ROBIN_EN
    // rotating-priority pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_pe_req_arbiter.sv
// tb_pe_req_arbiter: directed and randomized checks of pe_req_arbiter
// against a cycle-level behavioural model of the grant rules.
module tb_pe_req_arbiter;

    localparam int N        = 3;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_vld;
    logic           timeout;

    int total;
    int bad;

    // model state: phase 0 = free, 1 = owned, 2 = dead cycle
    int           m_phase;
    int           m_owner;
    int           m_ten;
    int           m_ptr;
    logic [N-1:0] m_block;
    logic [N-1:0] e_gnt;
    logic [IDW-1:0] e_id;
    logic         e_vld;
    logic         e_to;

`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    pe_req_arbiter #(
        .N(N),
        .IDW(IDW),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .gnt_vld(gnt_vld),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input logic rst, input logic [N-1:0] r);
        logic [N-1:0] elig;
        logic [N-1:0] setm;
        int w;
        bit found;
        setm = '0;
        e_to = 1'b0;
        if (!rst) begin
            m_phase = 0;
            m_owner = 0;
            m_ten   = 0;
            m_ptr   = 0;
            m_block = '0;
        end else begin
            case (m_phase)
                0: begin
                    elig  = r & ~m_block;
                    found = 0;
                    w     = 0;
                    if (RR) begin
                        for (int k = 0; k < N; k++) begin
                            if (!found && elig[(m_ptr + k) % N]) begin
                                w = (m_ptr + k) % N;
                                found = 1;
                            end
                        end
                    end else begin
                        for (int i = N - 1; i >= 0; i--) begin
                            if (!found && elig[i]) begin
                                w = i;
                                found = 1;
                            end
                        end
                    end
                    if (found) begin
                        m_owner = w;
                        m_ten   = 1;
                        m_phase = 1;
                        m_ptr   = (w + 1) % N;
                    end
                end
                1: begin
                    if (!r[m_owner]) begin
                        m_phase = 2;
                    end else if (m_ten == MAX_HOLD) begin
                        m_phase = 2;
                        e_to = 1'b1;
                        setm[m_owner] = 1'b1;
                    end else begin
                        m_ten++;
                    end
                end
                default: m_phase = 0;
            endcase
            m_block = (m_block & r) | setm;
        end
        e_vld = (m_phase == 1);
        e_gnt = e_vld ? (N'(1) << m_owner) : '0;
        e_id  = e_vld ? IDW'(m_owner) : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst_n, req);
        #1;
    endtask

    task automatic drain();
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [N-1:0]   want_g;
        logic [IDW-1:0] want_id;
        rst_n = 1'b0;
        req   = 3'b111;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (gnt !== 3'b000) begin
                bad++;
                $display("FAIL reset_gnt: got %b want 000", gnt);
            end
            total++;
            if (gnt_id !== 2'd0 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL reset_out: got id=%0d vld=%b to=%b want 0", gnt_id, gnt_vld, timeout);
            end
        end
        rst_n = 1'b1;
        tick();
        want_g  = RR ? 3'b001 : 3'b100;
        want_id = RR ? 2'd0 : 2'd2;
        total++;
        if (gnt !== want_g || gnt_id !== want_id || gnt_vld !== 1'b1) begin
            bad++;
            $display("FAIL first_grant: got gnt=%b id=%0d vld=%b want gnt=%b id=%0d vld=1",
                     gnt, gnt_id, gnt_vld, want_g, want_id);
        end
        drain();
    endtask

    task automatic test_release();
        int hi;
        int to;
        hi = 0;
        to = 0;
        req = 3'b010;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) req = '0;
            tick();
            if (gnt === 3'b010 && gnt_id === 2'd1) hi++;
            if (timeout === 1'b1) to++;
            if (c == 3) begin
                total++;
                if (gnt_vld !== 1'b0) begin
                    bad++;
                    $display("FAIL release_gap: got vld=%b want 0", gnt_vld);
                end
            end
        end
        total++;
        if (hi != 3) begin
            bad++;
            $display("FAIL release_len: got %0d cycles want 3", hi);
        end
        total++;
        if (to != 0) begin
            bad++;
            $display("FAIL release_to: got %0d pulses want 0", to);
        end
    endtask

    task automatic test_timeout();
        int hi;
        int to;
        int to_at;
        hi = 0;
        to = 0;
        to_at = -1;
        req = 3'b001;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt === 3'b001) hi++;
            if (timeout === 1'b1) begin
                to++;
                to_at = c;
            end
        end
        total++;
        if (hi != MAX_HOLD) begin
            bad++;
            $display("FAIL hold_len: got %0d cycles want %0d", hi, MAX_HOLD);
        end
        total++;
        if (to != 1 || to_at != MAX_HOLD) begin
            bad++;
            $display("FAIL timeout_pulse: got %0d pulses at %0d want 1 at %0d", to, to_at, MAX_HOLD);
        end
        req = '0;
        tick();
        req = 3'b001;
        tick();
        total++;
        if (gnt !== 3'b001 || gnt_vld !== 1'b1) begin
            bad++;
            $display("FAIL regrant: got gnt=%b vld=%b want 001 1", gnt, gnt_vld);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int seq[$];
        int start[$];
        logic [N-1:0] drop;
        logic prev;
        int want;
        rst_n = 1'b0;
        req = '0;
        tick();
        rst_n = 1'b1;
        prev = 1'b0;
        for (int c = 0; c < 60; c++) begin
            drop = '0;
            if (m_phase == 1 && m_ten == 2) drop[m_owner] = 1'b1;
            req = 3'b111 & ~drop;
            tick();
            if (gnt_vld === 1'b1 && !prev) begin
                seq.push_back(int'(gnt_id));
                start.push_back(c);
            end
            prev = gnt_vld;
        end
        for (int i = 0; i < 6; i++) begin
            want = RR ? (i % 3) : 2;
            total++;
            if (i >= seq.size()) begin
                bad++;
                $display("FAIL b2b_seq[%0d]: got none want %0d", i, want);
            end else if (seq[i] != want) begin
                bad++;
                $display("FAIL b2b_seq[%0d]: got %0d want %0d", i, seq[i], want);
            end
            if (i > 0 && i < start.size()) begin
                total++;
                if (start[i] - start[i-1] != 4) begin
                    bad++;
                    $display("FAIL b2b_gap[%0d]: got %0d want 4", i, start[i] - start[i-1]);
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] want_g;
        req = 3'b010;
        tick();
        total++;
        if (gnt !== 3'b010 || gnt_id !== 2'd1) begin
            bad++;
            $display("FAIL mid_setup: got gnt=%b id=%0d want 010 1", gnt, gnt_id);
        end
        tick();
        rst_n = 1'b0;
        req = 3'b111;
        tick();
        total++;
        if (gnt !== 3'b000 || gnt_vld !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got gnt=%b vld=%b want 000 0", gnt, gnt_vld);
        end
        rst_n = 1'b1;
        tick();
        want_g = RR ? 3'b001 : 3'b100;
        total++;
        if (gnt !== want_g) begin
            bad++;
            $display("FAIL mid_fresh: got gnt=%b want %b", gnt, want_g);
        end
        drain();
    endtask

    task automatic test_random();
        int len;
        for (int c = 0; c < 600; c += len) begin
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(9, 20) : $urandom_range(1, 6);
            req = N'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 40) != 0);
            for (int j = 0; j < len; j++) begin
                tick();
                rst_n = 1'b1;
                total++;
                if (gnt !== e_gnt || gnt_id !== e_id) begin
                    bad++;
                    $display("FAIL rnd_gnt@%0d: got gnt=%b id=%0d want gnt=%b id=%0d",
                             c + j, gnt, gnt_id, e_gnt, e_id);
                end
                total++;
                if (gnt_vld !== e_vld || timeout !== e_to) begin
                    bad++;
                    $display("FAIL rnd_flags@%0d: got vld=%b to=%b want vld=%b to=%b",
                             c + j, gnt_vld, timeout, e_vld, e_to);
                end
            end
        end
        drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = '0;
        m_phase = 0;
        m_owner = 0;
        m_ten   = 0;
        m_ptr   = 0;
        m_block = '0;
        #1;
        test_reset();
        test_release();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
